// File: rtl/jtag_dtm_if.sv
// DMI trivial-bus bundle between the JTAG DTM (master) and the debug module (slave).
interface jtag_dtm_if;
  logic        dmi_start;
  logic        dmi_finish;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i;

  modport master (
    output dmi_start, dmi_op, dmi_address, dmi_data_o,
    input  dmi_finish, dmi_data_i
  );

  modport slave (
    input  dmi_start, dmi_op, dmi_address, dmi_data_o,
    output dmi_finish, dmi_data_i
  );
endinterface

// File: rtl/jtag_dtm.sv
// RISC-V JTAG Debug Transport Module, single clock domain.
// JTAG pins are oversampled on clk; tck edges become one-cycle events that step
// the TAP controller. IDCODE, DTMCS, DMI and BYPASS data registers are provided,
// and DMI updates launch requests on the DMI trivial bus.
module jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1BEE_F001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  jtag_dtm_if.master bus
);

  // TAP controller states
  localparam logic [3:0] TLR   = 4'd0;
  localparam logic [3:0] RTI   = 4'd1;
  localparam logic [3:0] SELDR = 4'd2;
  localparam logic [3:0] CAPDR = 4'd3;
  localparam logic [3:0] SHDR  = 4'd4;
  localparam logic [3:0] EX1DR = 4'd5;
  localparam logic [3:0] PADR  = 4'd6;
  localparam logic [3:0] EX2DR = 4'd7;
  localparam logic [3:0] UPDR  = 4'd8;
  localparam logic [3:0] SELIR = 4'd9;
  localparam logic [3:0] CAPIR = 4'd10;
  localparam logic [3:0] SHIR  = 4'd11;
  localparam logic [3:0] EX1IR = 4'd12;
  localparam logic [3:0] PAIR  = 4'd13;
  localparam logic [3:0] EX2IR = 4'd14;
  localparam logic [3:0] UPIR  = 4'd15;

  // Request engine states
  localparam logic [1:0] RIDLE  = 2'd0;
  localparam logic [1:0] RSTART = 2'd1;
  localparam logic [1:0] RWAIT  = 2'd2;

  // Data register selection decoded from IR
  localparam logic [1:0] SEL_IDCODE = 2'd0;
  localparam logic [1:0] SEL_DTMCS  = 2'd1;
  localparam logic [1:0] SEL_DMI    = 2'd2;
  localparam logic [1:0] SEL_BYPASS = 2'd3;

  logic        r_tck_s1, r_tck_s2, r_tck_s3;
  logic        r_tms_s1, r_tms_s2;
  logic        r_tdi_s1, r_tdi_s2;
  logic        r_rise, r_fall;
  logic        r_tms_e, r_tdi_e;

  logic [3:0]  r_tap;
  logic [3:0]  w_tap_next;
  logic [4:0]  r_ir;
  logic [4:0]  r_ir_sh;
  logic [40:0] r_dr;
  logic [1:0]  w_sel;

  logic        r_sticky;
  logic        r_discard;
  logic [1:0]  r_eng;
  logic [31:0] r_result;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_op;
  logic        r_tdo;

  logic [31:0] w_dtmcs;
  logic [1:0]  w_dmi_stat;
  logic        w_cap_dmi;
  logic        w_upd_dmi;
  logic        w_upd_dtmcs;
  logic        w_enter_tlr;
  logic        w_finish;
  logic        w_busy;
  logic        w_op_valid;
  logic        w_accept;

  // Two-flop synchronizers plus a third tck flop; edges are registered as one-cycle events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tck_s1 <= 1'b0;
      r_tck_s2 <= 1'b0;
      r_tck_s3 <= 1'b0;
      r_tms_s1 <= 1'b0;
      r_tms_s2 <= 1'b0;
      r_tdi_s1 <= 1'b0;
      r_tdi_s2 <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_tms_e  <= 1'b0;
      r_tdi_e  <= 1'b0;
    end else begin
      r_tck_s1 <= tck;
      r_tck_s2 <= r_tck_s1;
      r_tck_s3 <= r_tck_s2;
      r_tms_s1 <= tms;
      r_tms_s2 <= r_tms_s1;
      r_tdi_s1 <= tdi;
      r_tdi_s2 <= r_tdi_s1;
      r_rise   <= r_tck_s2 & ~r_tck_s3;
      r_fall   <= ~r_tck_s2 & r_tck_s3;
      r_tms_e  <= r_tms_s2;
      r_tdi_e  <= r_tdi_s2;
    end
  end

  // IEEE 1149.1 TAP next-state function driven by the sampled tms
  always_comb begin
    w_tap_next = r_tap;
    case (r_tap)
      TLR:     w_tap_next = r_tms_e ? TLR   : RTI;
      RTI:     w_tap_next = r_tms_e ? SELDR : RTI;
      SELDR:   w_tap_next = r_tms_e ? SELIR : CAPDR;
      CAPDR:   w_tap_next = r_tms_e ? EX1DR : SHDR;
      SHDR:    w_tap_next = r_tms_e ? EX1DR : SHDR;
      EX1DR:   w_tap_next = r_tms_e ? UPDR  : PADR;
      PADR:    w_tap_next = r_tms_e ? EX2DR : PADR;
      EX2DR:   w_tap_next = r_tms_e ? UPDR  : SHDR;
      UPDR:    w_tap_next = r_tms_e ? SELDR : RTI;
      SELIR:   w_tap_next = r_tms_e ? TLR   : CAPIR;
      CAPIR:   w_tap_next = r_tms_e ? EX1IR : SHIR;
      SHIR:    w_tap_next = r_tms_e ? EX1IR : SHIR;
      EX1IR:   w_tap_next = r_tms_e ? UPIR  : PAIR;
      PAIR:    w_tap_next = r_tms_e ? EX2IR : PAIR;
      EX2IR:   w_tap_next = r_tms_e ? UPIR  : SHIR;
      UPIR:    w_tap_next = r_tms_e ? SELDR : RTI;
      default: w_tap_next = TLR;
    endcase
  end

  // Unknown IR codes fall back to BYPASS
  always_comb begin
    case (r_ir)
      5'h01:   w_sel = SEL_IDCODE;
      5'h10:   w_sel = SEL_DTMCS;
      5'h11:   w_sel = SEL_DMI;
      default: w_sel = SEL_BYPASS;
    endcase
  end

  assign w_dtmcs     = {17'b0, 3'd1, {2{r_sticky}}, 6'd7, 4'd1};
  assign w_dmi_stat  = ((r_eng != RIDLE) || r_sticky) ? 2'd3 : 2'd0;
  assign w_cap_dmi   = r_rise && (r_tap == CAPDR) && (w_sel == SEL_DMI);
  assign w_upd_dmi   = r_rise && (r_tap == UPDR) && (w_sel == SEL_DMI);
  assign w_upd_dtmcs = r_rise && (r_tap == UPDR) && (w_sel == SEL_DTMCS);
  assign w_enter_tlr = r_rise && (w_tap_next == TLR);
  assign w_finish    = (r_eng == RWAIT) && bus.dmi_finish;
  // A finish in this very cycle frees the engine for a same-cycle update
  assign w_busy      = (r_eng == RSTART) || ((r_eng == RWAIT) && !bus.dmi_finish);
  assign w_op_valid  = (r_dr[1:0] == 2'd1) || (r_dr[1:0] == 2'd2);
  assign w_accept    = w_upd_dmi && w_op_valid && !w_busy && !r_sticky;

  // TAP state advances once per tck rise event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap <= TLR;
    end else if (r_rise) begin
      r_tap <= w_tap_next;
    end
  end

  // Instruction register: forced to IDCODE on entering TLR, loaded on leaving Update-IR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= 5'h01;
    end else if (r_rise) begin
      if (w_tap_next == TLR) begin
        r_ir <= 5'h01;
      end else if (r_tap == UPIR) begin
        r_ir <= r_ir_sh;
      end
    end
  end

  // IR shift path, LSB first
  always_ff @(posedge clk) begin
    if (r_rise) begin
      if (r_tap == CAPIR) begin
        r_ir_sh <= 5'b00001;
      end else if (r_tap == SHIR) begin
        r_ir_sh <= {r_tdi_e, r_ir_sh[4:1]};
      end
    end
  end

  // Shared DR shift path; tdi enters at the MSB of the selected register's length
  always_ff @(posedge clk) begin
    if (r_rise) begin
      if (r_tap == CAPDR) begin
        case (w_sel)
          SEL_IDCODE: r_dr <= {9'b0, IDCODE};
          SEL_DTMCS:  r_dr <= {9'b0, w_dtmcs};
          SEL_DMI:    r_dr <= {r_addr, r_result, w_dmi_stat};
          default:    r_dr <= 41'b0;
        endcase
      end else if (r_tap == SHDR) begin
        case (w_sel)
          SEL_IDCODE,
          SEL_DTMCS:  r_dr[31:0] <= {r_tdi_e, r_dr[31:1]};
          SEL_DMI:    r_dr       <= {r_tdi_e, r_dr[40:1]};
          default:    r_dr[0]    <= r_tdi_e;
        endcase
      end
    end
  end

  // Request engine, sticky error and stored result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eng     <= RIDLE;
      r_sticky  <= 1'b0;
      r_discard <= 1'b0;
      r_result  <= 32'b0;
      r_addr    <= 7'b0;
      r_wdata   <= 32'b0;
      r_op      <= 2'b0;
    end else begin
      case (r_eng)
        RSTART:  r_eng <= RWAIT;
        RWAIT:   if (bus.dmi_finish) r_eng <= RIDLE;
        default: r_eng <= r_eng;
      endcase

      if (w_finish) begin
        if ((r_op == 2'd1) && !r_discard) r_result <= bus.dmi_data_i;
        r_discard <= 1'b0;
      end

      if (w_cap_dmi && (r_eng != RIDLE)) r_sticky <= 1'b1;
      if (w_upd_dmi && w_op_valid && w_busy) r_sticky <= 1'b1;

      if (w_accept) begin
        r_eng   <= RSTART;
        r_addr  <= r_dr[40:34];
        r_wdata <= r_dr[33:2];
        r_op    <= r_dr[1:0];
      end

      if (w_upd_dtmcs && (r_dr[16] || r_dr[17])) r_sticky <= 1'b0;
      if (w_upd_dtmcs && r_dr[17]) begin
        r_result <= 32'b0;
        if (w_busy) r_discard <= 1'b1;
      end

      if (w_enter_tlr) r_sticky <= 1'b0;
    end
  end

  // tdo changes only on tck fall events, and only shift states drive data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdo <= 1'b0;
    end else if (r_fall) begin
      if (r_tap == SHIR) begin
        r_tdo <= r_ir_sh[0];
      end else if (r_tap == SHDR) begin
        r_tdo <= r_dr[0];
      end else begin
        r_tdo <= 1'b0;
      end
    end
  end

  assign tdo             = r_tdo;
  assign bus.dmi_start   = (r_eng == RSTART);
  assign bus.dmi_op      = r_op;
  assign bus.dmi_address = r_addr;
  assign bus.dmi_data_o  = r_wdata;

endmodule

// File: tb/tb_jtag_dtm.sv
// Self-checking bench for jtag_dtm: table of register scans, hand-written DMI
// corner sequences, and a randomized DMI run checked against a memory-level model.
module tb_jtag_dtm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic tdo;

  jtag_dtm_if bus();

  jtag_dtm #(.IDCODE(32'h1BEE_F001)) dut (
    .clk (clk),
    .rst (rst),
    .tck (tck),
    .tms (tms),
    .tdi (tdi),
    .tdo (tdo),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // debug-module model controls and observations
  int          dm_delay  = 2;
  int          starts    = 0;
  int          spur_req  = 0;
  logic [6:0]  log_addr  = '0;
  logic [1:0]  log_op    = '0;
  logic [31:0] log_data  = '0;
  logic [31:0] dm_mem  [128];
  logic [31:0] ref_mem [128];

  typedef struct {
    string       name;
    bit          set_ir;
    logic [4:0]  ir;
    logic [40:0] din;
    int          n;
    logic [40:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] init_val(int i);
    if (i == 17) return 32'h0000_0C82;
    return 32'hA5A5_0000 ^ 32'(i * 257);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Debug module: counts start pulses, answers after dm_delay cycles, and can
  // emit a spurious finish on request
  initial begin : dm_model
    int cnt;
    int spur_done;
    bit pend;
    logic [6:0]  p_addr;
    logic [1:0]  p_op;
    logic [31:0] p_data;
    cnt = 0; spur_done = 0; pend = 0;
    p_addr = '0; p_op = '0; p_data = '0;
    bus.dmi_finish = 1'b0;
    bus.dmi_data_i = '0;
    for (int i = 0; i < 128; i++) dm_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      bus.dmi_finish = 1'b0;
      if (bus.dmi_start) begin
        starts++;
        log_addr = bus.dmi_address;
        log_op   = bus.dmi_op;
        log_data = bus.dmi_data_o;
        p_addr = bus.dmi_address; p_op = bus.dmi_op; p_data = bus.dmi_data_o;
        pend = 1; cnt = dm_delay;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 0;
          if (p_op == 2'd2) dm_mem[p_addr] = p_data;
          bus.dmi_data_i = (p_op == 2'd1) ? dm_mem[p_addr] : 32'hDEAD_BEEF;
          bus.dmi_finish = 1'b1;
        end
      end else if (spur_req != spur_done) begin
        spur_done = spur_req;
        bus.dmi_data_i = 32'hBAD0_BAD0;
        bus.dmi_finish = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_s);
    tms = tms_v;
    tdi = tdi_v;
    #50;
    tdo_s = tdo;
    tck = 1'b1;
    #50;
    tck = 1'b0;
  endtask

  task automatic tap_reset();
    logic d;
    repeat (5) tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
    logic d;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    o = '0;
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], d);
      o[i] = d;
    end
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic scan_dr(input logic [40:0] v, input int n, output logic [40:0] o);
    logic d;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    o = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, v[i], d);
      o[i] = d;
    end
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] dt, input logic [1:0] op,
                          output logic [40:0] o);
    scan_dr({a, dt, op}, 41, o);
    repeat (20) @(posedge clk);
  endtask

  initial begin : main
    logic [40:0] o;
    logic [4:0]  io;
    logic        d;
    int          s0;
    logic [6:0]  m_addr;
    logic [31:0] m_result;
    logic [6:0]  ra;
    logic [31:0] rd;
    logic [1:0]  rop;

    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

    vecs[0] = '{"idcode_rst", 1'b0, 5'h00, 41'h0,  32, 41'h0_1BEE_F001};
    vecs[1] = '{"dtmcs",      1'b1, 5'h10, 41'h0,  32, 41'h0_0000_1071};
    vecs[2] = '{"bypass05",   1'b1, 5'h05, 41'hA5,  8, 41'h4A};
    vecs[3] = '{"bypass1f",   1'b1, 5'h1F, 41'h3C,  8, 41'h78};
    vecs[4] = '{"bypass00",   1'b1, 5'h00, 41'hFF,  8, 41'hFE};
    vecs[5] = '{"idcode",     1'b1, 5'h01, 41'h0,  32, 41'h0_1BEE_F001};

    // reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tdo",   64'(tdo), 64'd0);
    check("rst_start", 64'(bus.dmi_start), 64'd0);
    check("rst_op",    64'(bus.dmi_op), 64'd0);
    check("rst_addr",  64'(bus.dmi_address), 64'd0);
    check("rst_wdata", 64'(bus.dmi_data_o), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    tap_reset();

    // register table
    foreach (vecs[k]) begin
      if (vecs[k].set_ir) begin
        scan_ir(vecs[k].ir, io);
        check({vecs[k].name, "_ircap"}, 64'(io), 64'd1);
      end
      scan_dr(vecs[k].din, vecs[k].n, o);
      check(vecs[k].name, 64'(o), 64'(vecs[k].exp));
    end

    // TLR via tms from a bypass IR restores IDCODE
    scan_ir(5'h05, io);
    tap_reset();
    scan_dr(41'h0, 32, o);
    check("tlr_idcode", 64'(o), 64'h1BEE_F001);

    // DMI write
    scan_ir(5'h11, io);
    s0 = starts;
    dmi_scan(7'h10, 32'h1, 2'd2, o);
    ref_mem[16] = 32'h1;
    check("wr_starts", 64'(starts - s0), 64'd1);
    check("wr_addr",   64'(log_addr), 64'h10);
    check("wr_op",     64'(log_op), 64'd2);
    check("wr_data",   64'(log_data), 64'd1);
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("wr_cap", 64'(o), 64'({7'h10, 32'h0, 2'd0}));

    // DMI read
    s0 = starts;
    dmi_scan(7'h11, 32'h0, 2'd1, o);
    check("rd_starts", 64'(starts - s0), 64'd1);
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("rd_cap", 64'(o), 64'({7'h11, 32'h0000_0C82, 2'd0}));

    // busy error
    dm_delay = 200;
    s0 = starts;
    scan_dr({7'h11, 32'h0, 2'd1}, 41, o);
    scan_dr({7'h12, 32'h0, 2'd1}, 41, o);
    check("busy_op", 64'(o[1:0]), 64'd3);
    repeat (250) @(posedge clk);
    check("busy_starts", 64'(starts - s0), 64'd1);
    scan_ir(5'h10, io);
    scan_dr(41'h1_0000, 32, o);
    check("busy_dtmcs", 64'(o), 64'h1C71);
    scan_dr(41'h0, 32, o);
    check("dmireset_dtmcs", 64'(o), 64'h1071);
    dm_delay = 2;
    scan_ir(5'h11, io);
    s0 = starts;
    dmi_scan(7'h12, 32'h0, 2'd1, o);
    check("after_reset_cap", 64'(o), 64'({7'h11, 32'h0000_0C82, 2'd0}));
    check("after_reset_starts", 64'(starts - s0), 64'd1);

    // dmihardreset clears the stored result
    scan_ir(5'h10, io);
    scan_dr(41'h2_0000, 32, o);
    scan_ir(5'h11, io);
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("hardreset_cap", 64'(o), 64'({7'h12, 32'h0, 2'd0}));

    // finish outside RWAIT is ignored
    spur_req++;
    repeat (10) @(posedge clk);
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("spurious_cap", 64'(o), 64'({7'h12, 32'h0, 2'd0}));

    // reset mid-Shift-DR with a request in flight
    dm_delay = 200;
    scan_dr({7'h33, 32'h0, 2'd1}, 41, o);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b1, d);
    check("pre_rst_tdo",  64'(d), 64'd1);
    check("pre_rst_addr", 64'(bus.dmi_address), 64'h33);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_tdo",   64'(tdo), 64'd0);
    check("mid_rst_start", 64'(bus.dmi_start), 64'd0);
    check("mid_rst_op",    64'(bus.dmi_op), 64'd0);
    check("mid_rst_addr",  64'(bus.dmi_address), 64'd0);
    check("mid_rst_wdata", 64'(bus.dmi_data_o), 64'd0);
    rst = 1'b0;
    s0 = starts;
    tap_reset();
    repeat (250) @(posedge clk);
    dm_delay = 2;
    scan_ir(5'h11, io);
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("post_rst_cap",    64'(o), 64'd0);
    check("post_rst_starts", 64'(starts - s0), 64'd0);

    // randomized DMI traffic against a memory-level model
    m_addr = '0;
    m_result = '0;
    for (int it = 0; it < 16; it++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 7'($urandom_range(0, 127));
      rd  = $urandom;
      s0  = starts;
      dmi_scan(ra, rd, rop, o);
      check("rnd_cap", 64'(o), 64'({m_addr, m_result, 2'd0}));
      if (rop == 2'd1 || rop == 2'd2) begin
        check("rnd_starts", 64'(starts - s0), 64'd1);
        check("rnd_log", {23'b0, log_addr, log_op, log_data}, {23'b0, ra, rop, rd});
        m_addr = ra;
        if (rop == 2'd1) m_result = ref_mem[ra];
        else ref_mem[ra] = rd;
      end else begin
        check("rnd_nop_starts", 64'(starts - s0), 64'd0);
      end
    end
    dmi_scan(7'h0, 32'h0, 2'd0, o);
    check("rnd_final_cap", 64'(o), 64'({m_addr, m_result, 2'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_dtm.md
# jtag_dtm

Single-clock JTAG Debug Transport Module: oversamples the JTAG pins in the system clock domain, runs the IEEE 1149.1 TAP controller, and implements the RISC-V debug IDCODE, DTMCS, DMI and BYPASS registers. It is the initiator on the DMI trivial bus. It issues one-cycle `dmi_start` requests to the debug module and collects results on `dmi_finish`. It sits between the board JTAG pins and the DM, both on `clk`.

## Interface
- `IDCODE`, default 32'h1BEE_F001, value of the IDCODE register; bit 0 must be 1.
- `clk`  in  1  system clock; the DM uses the same clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tck`  in  1  JTAG clock, asynchronous to `clk`; must satisfy f(tck) ≤ f(clk)/8.
- `tms`  in  1  JTAG mode select, asynchronous.
- `tdi`  in  1  JTAG data in, asynchronous.
- `tdo`  out  1  JTAG data out.
- `dmi_start`  out  1  one-cycle request pulse to the DM.
- `dmi_finish`  in  1  one-cycle completion pulse from the DM.
- `dmi_op`  out  2  request op: 1 = read, 2 = write.
- `dmi_address`  out  7  DM register address.
- `dmi_data_o`  out  32  write data to the DM.
- `dmi_data_i`  in  32  read data from the DM; valid in the `dmi_finish` cycle.

## Operation
- **Pin sampling.** `tck`, `tms` and `tdi` each pass through 2-flop synchronizers. A third `tck` flop provides edge detection.
  - Rise event: advance the TAP and shift the selected register, using synchronized `tms`/`tdi`.
  - Fall event: update `tdo`.
- **TAP controller.** Standard 16-state FSM; reset state Test-Logic-Reset (TLR).
  - Entering TLR: IR ← 5'h01 and sticky error is cleared.
  - Entering TLR does not abort an in-flight DMI request.
- **IR.** 5 bits.
  - Capture-IR loads 5'b00001.
  - Decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI, 0x1F BYPASS. Any other value selects BYPASS.
- **All shift registers** shift LSB first: tdi enters at the MSB and `tdo` is the LSB.
- **BYPASS.** 1-bit register; Capture-DR loads 0.
- **DTMCS read value.**
  - [3:0] version = 1
  - [9:4] abits = 7
  - [11:10] dmistat = sticky error (0 or 3)
  - [14:12] idle = 1
  - all other bits 0
  - Result: 0x1071 with no error, 0x1C71 with sticky error set.
- **DTMCS update.**
  - bit16 `dmireset` clears the sticky error.
  - bit17 `dmihardreset` clears the sticky error and the stored result. A request already in flight still completes on the bus, but its read data is discarded.
- **DMI register.** 41 bits: [40:34] address, [33:2] data, [1:0] op.
  - Capture-DR loads {last address, result data, status}.
  - Status is 3 if a request is in flight or the sticky error is set, otherwise 0.
  - Capturing while a request is in flight also sets the sticky error.
- **DMI Update-DR** with op = 1 or 2:
  - If a request is in flight, set the sticky error and drop the update.
  - Else if the sticky error is set, drop the update.
  - Otherwise latch address, data and op, and launch a request.
  - op 0 and op 3 are no-ops.
- **Request engine.** States RIDLE → RSTART → RWAIT → RIDLE.
  - RSTART: `dmi_start` = 1 for exactly one cycle.
  - RWAIT: hold until `dmi_finish`. On finish, store `dmi_data_i` as the result data if op = 1; a write leaves the stored data unchanged.
  - `dmi_op`, `dmi_address` and `dmi_data_o` are stable from RSTART through the `dmi_finish` cycle. They keep their last value afterwards.
  - There is no timeout.
- **`tdo` drive.** On each fall event, `tdo` ← LSB of the active shift register while in Shift-IR or Shift-DR; otherwise `tdo` ← 0.

## Timing
- **Reset values** (all outputs): `tdo` = 0, `dmi_start` = 0, `dmi_op` = 0, `dmi_address` = 0, `dmi_data_o` = 0. Internal reset state: TAP in TLR, IR = 0x01, sticky error = 0, engine in RIDLE, result data = 0.
- Pin-to-event latency is 3 `clk` cycles. Each TAP step occurs in the `clk` cycle after the event is detected.
- **Request launch.** `dmi_start` asserts in the cycle after the TAP leaves Update-DR (DMI selected, request accepted).
- **Request completion.** The engine returns to RIDLE in the cycle after `dmi_finish`. A Capture-DR in that same later cycle sees the completed result.
- **`dmi_finish` outside RWAIT** is ignored.
- **Simultaneous events.** Update-DR and `dmi_finish` in the same cycle: the finish completes first and the new request is accepted.
- **Reset during a transaction.** `rst` mid-transaction returns to reset state immediately. A `dmi_finish` arriving after reset is ignored.

## Test plan
- **IDCODE after reset:** `rst` pulse, then Capture/Shift-DR 32 bits → `tdo` stream = 32'h1BEEF001, LSB first.
- **DTMCS read:** IR = 0x10, shift 32 bits → 0x00001071.
- **DMI write:** scan {7'h10, 32'h1, 2'd2} → one-cycle `dmi_start` with `dmi_address` = 0x10, `dmi_op` = 2, `dmi_data_o` = 1. DM model finishes after 2 cycles; the next DMI capture returns op = 0.
- **DMI read:** scan {7'h11, 0, 2'd1}. DM model returns 32'h00000C82 with `dmi_finish`. Next scan shifts out address 0x11, data 0xC82, op 0.
- **Busy error:** DM model delays `dmi_finish` by 200 cycles; a second read is scanned in meanwhile.
  - Expected: second read returns op = 3, issues no `dmi_start`, and DTMCS reads 0x1C71.
  - After writing DTMCS `dmireset`: status reads 0 and the next read launches normally.
- **BYPASS and TLR:** IR = 0x05 → 1-cycle delay tdi→tdo path.
  - Then tms = 1 for 5 `tck` → IR = 0x01, and IDCODE is readable.
  - Asserting `rst` mid-Shift-DR → all outputs return to 0.
